// File: rtl/miriscv_gpr_wb.sv
// miriscv_gpr_wb: writeback unit for the single GPR write port.
// Merges the single-cycle ALU path and the variable-latency LSU/MDU path into
// at most one register write per cycle; LSU results wait in a small FIFO.
// Optional scoreboard of pending destinations: define MIRISCV_WB_SCOREBOARD_EN.
//
// Handshake (LSU side): a result transfers on a rising edge when
// lsu_valid_i && lsu_ready_o. lsu_ready_o depends only on the FIFO count
// (not on a same-cycle pop), and a transfer offered during flush_i is dropped.
module miriscv_gpr_wb #(
  parameter int XLEN       = 32,
  parameter int GPR_ADDR_W = 5,
  parameter int LQ_DEPTH   = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        alu_valid_i,
  input  logic [GPR_ADDR_W-1:0]       alu_addr_i,
  input  logic [XLEN-1:0]             alu_data_i,
  input  logic                        lsu_valid_i,
  output logic                        lsu_ready_o,
  input  logic [GPR_ADDR_W-1:0]       lsu_addr_i,
  input  logic [XLEN-1:0]             lsu_data_i,
  input  logic                        issue_en_i,
  input  logic [GPR_ADDR_W-1:0]       issue_addr_i,
  input  logic                        flush_i,
  output logic [(1<<GPR_ADDR_W)-1:0]  busy_o,
  output logic                        gpr_wr_en_o,
  output logic [GPR_ADDR_W-1:0]       gpr_wr_addr_o,
  output logic [XLEN-1:0]             gpr_wr_data_o
);

  localparam int NUM_WORDS = 1 << GPR_ADDR_W;
  localparam int PTR_W     = $clog2(LQ_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  // LSU result FIFO state
  logic [GPR_ADDR_W-1:0] lq_addr_q [LQ_DEPTH];
  logic [GPR_ADDR_W-1:0] lq_addr_d [LQ_DEPTH];
  logic [XLEN-1:0]       lq_data_q [LQ_DEPTH];
  logic [XLEN-1:0]       lq_data_d [LQ_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Registered write port
  logic                  wr_en_q, wr_en_d;
  logic [GPR_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;

  // Arbiter results
  logic                  lq_empty;
  logic                  lq_push;
  logic                  lq_pop;
  logic                  sel_alu;
  logic                  sel_valid;
  logic [GPR_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;

  // Fixed-priority arbitration: flush, then ALU, then FIFO head
  always_comb begin
    lq_empty    = (count_q == '0);
    lsu_ready_o = (count_q != CNT_W'(LQ_DEPTH));
    lq_push     = lsu_valid_i && lsu_ready_o && !flush_i;
    sel_alu     = !flush_i && alu_valid_i;
    lq_pop      = !flush_i && !alu_valid_i && !lq_empty;
    sel_valid   = sel_alu || lq_pop;
    sel_addr    = sel_alu ? alu_addr_i : lq_addr_q[rd_ptr_q];
    sel_data    = sel_alu ? alu_data_i : lq_data_q[rd_ptr_q];
  end

  // Next state of the FIFO: pointers wrap naturally since depth is a power of two
  always_comb begin
    lq_addr_d = lq_addr_q;
    lq_data_d = lq_data_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (lq_push) begin
        lq_addr_d[wr_ptr_q] = lsu_addr_i;
        lq_data_d[wr_ptr_q] = lsu_data_i;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (lq_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({lq_push, lq_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next write-port value: x0 is consumed silently, addr/data hold when idle
  always_comb begin
    wr_en_d   = sel_valid && (sel_addr != '0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
  end

  // FIFO and write-port registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_addr_q[i] <= '0;
        lq_data_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      lq_addr_q <= lq_addr_d;
      lq_data_q <= lq_data_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign gpr_wr_en_o   = wr_en_q;
  assign gpr_wr_addr_o = wr_addr_q;
  assign gpr_wr_data_o = wr_data_q;

`ifdef MIRISCV_WB_SCOREBOARD_EN
  logic [NUM_WORDS-1:0] busy_q, busy_d;

  // Scoreboard: writeback clears, issue sets (set wins), flush clears all
  always_comb begin
    busy_d = busy_q;
    if (sel_valid) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (issue_en_i) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (flush_i) begin
      busy_d = '0;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_en_i, issue_addr_i};
  assign busy_o       = {NUM_WORDS{1'b0}};
`endif

endmodule

// File: tb/tb_miriscv_gpr_wb.sv
// Testbench for miriscv_gpr_wb: directed steps followed by a random phase,
// all checked against a queue-based reference model of the writeback rules.
module tb_miriscv_gpr_wb;

  localparam int XLEN       = 32;
  localparam int GPR_ADDR_W = 5;
  localparam int LQ_DEPTH   = 2;
  localparam int NUM_WORDS  = 1 << GPR_ADDR_W;
  localparam int REC_W      = GPR_ADDR_W + XLEN;
`ifdef MIRISCV_WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  alu_valid;
  logic [GPR_ADDR_W-1:0] alu_addr;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [GPR_ADDR_W-1:0] lsu_addr;
  logic [XLEN-1:0]       lsu_data;
  logic                  issue_en;
  logic [GPR_ADDR_W-1:0] issue_addr;
  logic                  flush;
  logic [NUM_WORDS-1:0]  busy;
  logic                  wr_en;
  logic [GPR_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;

  miriscv_gpr_wb #(
    .XLEN(XLEN), .GPR_ADDR_W(GPR_ADDR_W), .LQ_DEPTH(LQ_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
    .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr),
    .flush_i(flush), .busy_o(busy),
    .gpr_wr_en_o(wr_en), .gpr_wr_addr_o(wr_addr), .gpr_wr_data_o(wr_data)
  );

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [REC_W-1:0]      m_q[$];      // results held by the LSU FIFO, oldest first
  logic [REC_W-1:0]      exp_q[$];    // register writes expected at the next edge
  logic [NUM_WORDS-1:0]  m_busy;
  logic                  m_en;
  logic [GPR_ADDR_W-1:0] m_waddr;
  logic [XLEN-1:0]       m_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply this cycle's inputs to the model as the rules describe them.
  task automatic model_update();
    logic                  have;
    logic                  accept;
    logic [GPR_ADDR_W-1:0] a;
    logic [XLEN-1:0]       d;
    logic [REC_W-1:0]      ent;
    have = 1'b0;
    a    = '0;
    d    = '0;
    if (rst) begin
      m_q.delete();
      m_busy  = '0;
      m_en    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else if (flush) begin
      m_q.delete();
      m_busy = '0;
      m_en   = 1'b0;
    end else begin
      accept = lsu_valid && (m_q.size() < LQ_DEPTH);
      if (alu_valid) begin
        have = 1'b1; a = alu_addr; d = alu_data;
      end else if (m_q.size() > 0) begin
        ent  = m_q.pop_front();
        have = 1'b1;
        a    = ent[REC_W-1:XLEN];
        d    = ent[XLEN-1:0];
      end
      if (accept) m_q.push_back({lsu_addr, lsu_data});
      m_en = have && (a != 0);
      if (m_en) begin
        m_waddr = a;
        m_wdata = d;
        exp_q.push_back({a, d});
      end
      if (SB_EN) begin
        if (have) m_busy[a] = 1'b0;
        if (issue_en) m_busy[issue_addr] = 1'b1;
        m_busy[0] = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  // One clock: update model, take the edge, compare just after it.
  task automatic step();
    logic [REC_W-1:0] rec;
    model_update();
    @(posedge clk);
    #1;
    chk("wr_en", 64'(wr_en), 64'(m_en));
    chk("wr_addr", 64'(wr_addr), 64'(m_waddr));
    chk("wr_data", 64'(wr_data), 64'(m_wdata));
    chk("lsu_ready", 64'(lsu_ready), 64'(m_q.size() < LQ_DEPTH));
    chk("busy", 64'(busy), 64'(m_busy));
    if (wr_en === 1'b1) begin
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        rec = exp_q.pop_front();
        chk("wr_record", 64'({wr_addr, wr_data}), 64'(rec));
      end
    end
    exp_q.delete();
  endtask

  task automatic alu(input logic [GPR_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    alu_valid = 1'b1; alu_addr = a; alu_data = d;
  endtask

  task automatic lsu(input logic [GPR_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    lsu_valid = 1'b1; lsu_addr = a; lsu_data = d;
  endtask

  task automatic issue(input logic [GPR_ADDR_W-1:0] a);
    issue_en = 1'b1; issue_addr = a;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_q.delete(); exp_q.delete();
    m_busy = '0; m_en = 1'b0; m_waddr = '0; m_wdata = '0;
    idle();
    rst = 1'b1;
    step(); step();
    idle();
    step();
    chk("reset_ready", 64'(lsu_ready), 64'd1);
    chk("reset_wr_en", 64'(wr_en), 64'd0);

    // ALU-only write with scoreboard tracking of x5
    idle(); issue(5); step();
    chk("issue5_busy", 64'(busy[5]), 64'(SB_EN));
    idle(); alu(5, 32'hDEADBEEF); step();
    chk("alu_wr_en", 64'(wr_en), 64'd1);
    chk("alu_wr_addr", 64'(wr_addr), 64'd5);
    chk("alu_wr_data", 64'(wr_data), 64'hDEADBEEF);
    chk("alu_busy5_clr", 64'(busy[5]), 64'd0);
    idle(); step();
    chk("alu_after_en", 64'(wr_en), 64'd0);

    // LSU fill while the ALU keeps the port busy
    idle(); alu(10, 32'h0A0A_0A0A); lsu(1, 32'h1111_1111); step();
    idle(); alu(10, 32'h0B0B_0B0B); lsu(2, 32'h2222_2222); step();
    chk("fill_ready_low", 64'(lsu_ready), 64'd0);
    idle(); alu(10, 32'h0C0C_0C0C); lsu(3, 32'h3333_3333); step();
    idle(); lsu(3, 32'h3333_3333); step();
    chk("fill_first_addr", 64'(wr_addr), 64'd1);
    chk("fill_ready_back", 64'(lsu_ready), 64'd1);
    idle(); lsu(3, 32'h3333_3333); step();     // push and pop together at count 1
    chk("fill_second_addr", 64'(wr_addr), 64'd2);
    chk("fill_count_kept", 64'(lsu_ready), 64'd1);
    idle(); step();
    chk("fill_third_addr", 64'(wr_addr), 64'd3);
    idle(); step();

    // ALU and FIFO head colliding
    idle(); lsu(9, 32'h9999_0009); step();
    idle(); alu(7, 32'h7777_0007); step();
    chk("coll_alu_first", 64'(wr_addr), 64'd7);
    idle(); step();
    chk("coll_lsu_next", 64'(wr_addr), 64'd9);

    // x0 suppression on both the FIFO and the scoreboard
    idle(); lsu(0, 32'h0000_1234); step();
    idle(); issue(0); step();
    chk("x0_no_write", 64'(wr_en), 64'd0);
    chk("x0_busy0", 64'(busy[0]), 64'd0);

    // Flush with queued entries and pending bits
    idle(); issue(4); step();
    idle(); issue(6); alu(11, 32'hB0B0_0011); lsu(12, 32'hC0C0_0012); step();
    idle(); alu(11, 32'hB0B0_0111); lsu(13, 32'hC0C0_0013); step();
    idle(); flush = 1'b1; lsu(14, 32'hC0C0_0014); step();
    chk("flush_en", 64'(wr_en), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(lsu_ready), 64'd1);
    idle(); step();
    chk("flush_no_data", 64'(wr_en), 64'd0);

    // Same-cycle issue and writeback of x8
    idle(); alu(8, 32'h8888_8888); issue(8); step();
    chk("set_wins_busy8", 64'(busy[8]), 64'(SB_EN));

    // Mid-stream reset
    idle(); alu(15, 32'h1515_1515); lsu(16, 32'h1616_1616); issue(17); step();
    idle(); rst = 1'b1; lsu(18, 32'h1818_1818); step();
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    idle(); step();

    // Random phase
    for (int i = 0; i < 600; i++) begin
      idle();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) alu(5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 1) == 0) lsu(5'($urandom_range(0, 31)), $urandom);
      if (!flush && $urandom_range(0, 1) == 0) issue(5'($urandom_range(0, 31)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
